// File: rtl/rle_packet_arbiter.sv
// Round-robin packet arbiter sharing one run-length encoder between two byte sources.
// Optional macro RLE_STATS_EN adds stat_words, a saturating count of accepted output words.
module rle_packet_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         s0_data,
    input  logic                      s0_valid,
    input  logic                      s0_last,
    output logic                      s0_ready,
    input  logic [DATA_W-1:0]         s1_data,
    input  logic                      s1_valid,
    input  logic                      s1_last,
    output logic                      s1_ready,
    output logic [DATA_W+CNT_W-1:0]   m_data,
    output logic                      m_src,
    output logic                      m_last,
    output logic                      m_valid,
    input  logic                      m_ready
`ifdef RLE_STATS_EN
    ,
    output logic [15:0]               stat_words
`endif
);

    localparam logic [1:0]       ST_IDLE  = 2'd0;
    localparam logic [1:0]       ST_RUN   = 2'd1;
    localparam logic [1:0]       ST_FLUSH = 2'd2;
    localparam logic [CNT_W-1:0] RMAX     = {CNT_W{1'b1}};

    logic [1:0]              state_reg, state_next;
    logic                    grant_reg, grant_next;
    logic                    rr_reg, rr_next;
    logic                    have_run_reg, have_run_next;
    logic [DATA_W-1:0]       cur_val_reg, cur_val_next;
    logic [CNT_W-1:0]        cur_cnt_reg, cur_cnt_next;
    logic [DATA_W+CNT_W-1:0] m_data_reg, m_data_next;
    logic                    m_src_reg, m_src_next;
    logic                    m_last_reg, m_last_next;
    logic                    m_valid_reg, m_valid_next;

    logic [DATA_W-1:0]       src_data [2];
    logic [1:0]              src_valid;
    logic [1:0]              src_last;
    logic [1:0]              src_ready;
    logic                    slot_free;
    logic                    accept;
    logic [DATA_W-1:0]       sel_data;

    assign src_data[0] = s0_data;
    assign src_data[1] = s1_data;
    assign src_valid   = {s1_valid, s0_valid};
    assign src_last    = {s1_last, s0_last};

    // A byte may only be taken when the output register can absorb whatever it emits.
    assign slot_free = !m_valid_reg || m_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign src_ready[gi] = (state_reg == ST_RUN) && (grant_reg == 1'(gi)) && slot_free;
        end
    endgenerate

    assign s0_ready = src_ready[0];
    assign s1_ready = src_ready[1];
    assign sel_data = src_data[grant_reg];
    assign accept   = src_valid[grant_reg] && src_ready[grant_reg];

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        rr_next       = rr_reg;
        have_run_next = have_run_reg;
        cur_val_next  = cur_val_reg;
        cur_cnt_next  = cur_cnt_reg;
        m_data_next   = m_data_reg;
        m_src_next    = m_src_reg;
        m_last_next   = m_last_reg;
        m_valid_next  = m_valid_reg && !m_ready;

        case (state_reg)
            ST_IDLE: begin
                if (|src_valid) begin
                    grant_next = (src_valid == 2'b11) ? rr_reg : src_valid[1];
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (!have_run_reg) begin
                        have_run_next = 1'b1;
                        cur_val_next  = sel_data;
                        cur_cnt_next  = CNT_W'(1);
                    end else if (sel_data == cur_val_reg && cur_cnt_reg != RMAX) begin
                        cur_cnt_next = cur_cnt_reg + CNT_W'(1);
                    end else begin
                        // Run broken or saturated: push the held run out, start afresh.
                        m_valid_next = 1'b1;
                        m_data_next  = {cur_val_reg, cur_cnt_reg};
                        m_src_next   = grant_reg;
                        m_last_next  = 1'b0;
                        cur_val_next = sel_data;
                        cur_cnt_next = CNT_W'(1);
                    end
                    if (src_last[grant_reg]) begin
                        state_next = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (slot_free) begin
                    m_valid_next  = 1'b1;
                    m_data_next   = {cur_val_reg, cur_cnt_reg};
                    m_src_next    = grant_reg;
                    m_last_next   = 1'b1;
                    have_run_next = 1'b0;
                    cur_val_next  = '0;
                    cur_cnt_next  = '0;
                    rr_next       = !grant_reg;
                    state_next    = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= 1'b0;
            rr_reg       <= 1'b0;
            have_run_reg <= 1'b0;
            cur_val_reg  <= '0;
            cur_cnt_reg  <= '0;
            m_data_reg   <= '0;
            m_src_reg    <= 1'b0;
            m_last_reg   <= 1'b0;
            m_valid_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            rr_reg       <= rr_next;
            have_run_reg <= have_run_next;
            cur_val_reg  <= cur_val_next;
            cur_cnt_reg  <= cur_cnt_next;
            m_data_reg   <= m_data_next;
            m_src_reg    <= m_src_next;
            m_last_reg   <= m_last_next;
            m_valid_reg  <= m_valid_next;
        end
    end

    assign m_data  = m_data_reg;
    assign m_src   = m_src_reg;
    assign m_last  = m_last_reg;
    assign m_valid = m_valid_reg;

`ifdef RLE_STATS_EN
    logic [15:0] stat_words_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words_reg <= '0;
        end else if (m_valid_reg && m_ready && stat_words_reg != 16'hFFFF) begin
            stat_words_reg <= stat_words_reg + 16'd1;
        end
    end

    assign stat_words = stat_words_reg;
`endif

endmodule

// File: tb/tb_rle_packet_arbiter.sv
// Self-checking bench for rle_packet_arbiter: directed packets plus random traffic
// scored against a per-source run-length model built from whole packets.
module tb_rle_packet_arbiter;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic [7:0]  s0_data  = '0;
    logic        s0_valid = 1'b0;
    logic        s0_last  = 1'b0;
    logic        s0_ready;
    logic [7:0]  s1_data  = '0;
    logic        s1_valid = 1'b0;
    logic        s1_last  = 1'b0;
    logic        s1_ready;
    logic [15:0] m_data;
    logic        m_src;
    logic        m_last;
    logic        m_valid;
    logic        m_ready  = 1'b0;
`ifdef RLE_STATS_EN
    logic [15:0] stat_words;
`endif

    always #5 clk = ~clk;

    rle_packet_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s0_data  (s0_data),
        .s0_valid (s0_valid),
        .s0_last  (s0_last),
        .s0_ready (s0_ready),
        .s1_data  (s1_data),
        .s1_valid (s1_valid),
        .s1_last  (s1_last),
        .s1_ready (s1_ready),
        .m_data   (m_data),
        .m_src    (m_src),
        .m_last   (m_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
`ifdef RLE_STATS_EN
        ,
        .stat_words (stat_words)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [8:0]  q0[$];       // {last, byte} waiting to be offered by S0
    logic [8:0]  q1[$];
    logic [16:0] exp0[$];     // {last, value, count} expected from S0 packets
    logic [16:0] exp1[$];
    logic [17:0] out_log[$];  // {src, last, data} of every accepted word
    logic [7:0]  pkt[$];

    int   valid_pct  = 100;
    int   ready_pct  = 100;
    int   cyc        = 0;
    int   stall_from = 0;
    int   stall_to   = 0;
    int   words_seen = 0;
    bit   prev_stall = 1'b0;
    bit   in_pkt     = 1'b0;
    bit   pkt_src    = 1'b0;
    logic [18:0] prev_out = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [17:0] log_at(input int k);
        if (k < out_log.size()) return out_log[k];
        return 'x;
    endfunction

    // Queue pkt on source s and derive its words: each run of equal bytes splits
    // into 255-long chunks plus a remainder; the packet's final word carries last.
    task automatic add_packet(input int s);
        int n, i, run, rem, c;
        logic lastw;
        n = pkt.size();
        for (int k = 0; k < n; k++) begin
            if (s == 0) q0.push_back({k == n - 1, pkt[k]});
            else        q1.push_back({k == n - 1, pkt[k]});
        end
        i = 0;
        while (i < n) begin
            run = 1;
            while (i + run < n && pkt[i + run] == pkt[i]) run++;
            rem = run;
            while (rem > 0) begin
                c = (rem > 255) ? 255 : rem;
                rem -= c;
                lastw = (i + run == n) && (rem == 0);
                if (s == 0) exp0.push_back({lastw, pkt[i], c[7:0]});
                else        exp1.push_back({lastw, pkt[i], c[7:0]});
            end
            i += run;
        end
        pkt.delete();
    endtask

    // One clock: drive at posedge+1, observe at negedge, retire handshakes at posedge.
    task automatic cycle();
        bit hs0, hs1, acc;
        logic [16:0] e;
        s0_valid = (q0.size() > 0) && (int'($urandom_range(99)) < valid_pct);
        s0_data  = s0_valid ? q0[0][7:0] : 8'($urandom);
        s0_last  = s0_valid ? q0[0][8] : 1'($urandom);
        s1_valid = (q1.size() > 0) && (int'($urandom_range(99)) < valid_pct);
        s1_data  = s1_valid ? q1[0][7:0] : 8'($urandom);
        s1_last  = s1_valid ? q1[0][8] : 1'($urandom);
        m_ready  = (cyc >= stall_from && cyc < stall_to) ? 1'b0
                                                         : (int'($urandom_range(99)) < ready_pct);
        @(negedge clk);
        check("one_grant", s0_ready & s1_ready, 0);
        check("ready_gate", (s0_ready | s1_ready) & m_valid & ~m_ready, 0);
        if (prev_stall) check("hold", {m_valid, m_src, m_last, m_data}, prev_out);
        prev_stall = m_valid & ~m_ready;
        prev_out   = {m_valid, m_src, m_last, m_data};
        hs0 = s0_valid & s0_ready;
        hs1 = s1_valid & s1_ready;
        acc = m_valid & m_ready;
        if (acc) begin
            out_log.push_back({m_src, m_last, m_data});
            if (in_pkt) check("no_interleave", m_src, pkt_src);
            in_pkt  = !m_last;
            pkt_src = m_src;
            check("word_expected", (m_src ? exp1.size() : exp0.size()) > 0, 1);
            if (!m_src && exp0.size() > 0) begin
                e = exp0.pop_front();
                check("word_s0", {m_last, m_data}, e);
            end else if (m_src && exp1.size() > 0) begin
                e = exp1.pop_front();
                check("word_s1", {m_last, m_data}, e);
            end
        end
        @(posedge clk);
        if (hs0) q0.delete(0);
        if (hs1) q1.delete(0);
        if (acc) words_seen++;
        cyc++;
        #1;
    endtask

    task automatic run_drain(input int max_cyc);
        int n;
        n = 0;
        while ((q0.size() + q1.size() + exp0.size() + exp1.size()) != 0 && n < max_cyc) begin
            cycle();
            n++;
        end
        check("drain_done", (q0.size() + q1.size() + exp0.size() + exp1.size()) == 0, 1);
        repeat (5) cycle();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        m_ready  = 1'b0;
        q0.delete();
        q1.delete();
        exp0.delete();
        exp1.delete();
        out_log.delete();
        in_pkt     = 1'b0;
        prev_stall = 1'b0;
        words_seen = 0;
        stall_from = 0;
        stall_to   = 0;
        #1;
        check("rst_outputs", {m_valid, m_src, m_last, m_data, s0_ready, s1_ready}, 0);
`ifdef RLE_STATS_EN
        check("rst_stats", stat_words, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  order;
        logic [17:0] lv;
        int          s, len;
        logic [7:0]  b;

        #2;
        do_reset();

        // Basic packet: 41 x3 then 42 with last.
        pkt.push_back(8'h41); pkt.push_back(8'h41); pkt.push_back(8'h41); pkt.push_back(8'h42);
        add_packet(0);
        run_drain(200);
        check("t1_count", out_log.size(), 2);
        check("t1_w0", log_at(0), {1'b0, 1'b0, 16'h4103});
        check("t1_w1", log_at(1), {1'b0, 1'b1, 16'h4201});
`ifdef RLE_STATS_EN
        check("t1_stats", stat_words, 2);
`endif

        // Both sources contending with single-byte packets: strict alternation from S0.
        do_reset();
        pkt.push_back(8'h11); add_packet(0);
        pkt.push_back(8'h22); add_packet(1);
        pkt.push_back(8'h33); add_packet(0);
        pkt.push_back(8'h44); add_packet(1);
        run_drain(200);
        check("t2_count", out_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            lv = log_at(k);
            order[3 - k] = lv[17];
        end
        check("t2_order", order, 4'b0101);
        check("t2_w1", log_at(1), {1'b1, 1'b1, 16'h2201});

        // Saturation: 256 identical bytes on S1.
        do_reset();
        for (int k = 0; k < 256; k++) pkt.push_back(8'h07);
        add_packet(1);
        run_drain(1000);
        check("t3_count", out_log.size(), 2);
        check("t3_w0", log_at(0), {1'b1, 1'b0, 16'h07FF});
        check("t3_w1", log_at(1), {1'b1, 1'b1, 16'h0701});

        // Downstream stalled for 10 cycles in the middle of a packet.
        do_reset();
        pkt.push_back(8'h01); pkt.push_back(8'h01); pkt.push_back(8'h02); pkt.push_back(8'h03);
        pkt.push_back(8'h03); pkt.push_back(8'h03); pkt.push_back(8'h04); pkt.push_back(8'h05);
        add_packet(0);
        stall_from = cyc + 5;
        stall_to   = cyc + 15;
        run_drain(200);
        check("t4_count", out_log.size(), 5);
        check("t4_w2", log_at(2), {1'b0, 1'b0, 16'h0303});
        check("t4_w4", log_at(4), {1'b0, 1'b1, 16'h0501});

        // Single-byte packet, then everything quiet.
        do_reset();
        pkt.push_back(8'hAA);
        add_packet(0);
        run_drain(200);
        check("t5_count", out_log.size(), 1);
        check("t5_w0", log_at(0), {1'b0, 1'b1, 16'hAA01});
        check("t5_idle", {s0_ready, s1_ready, m_valid}, 0);

        // Reset in the middle of a packet while a word is held.
        do_reset();
        q0.push_back({1'b0, 8'h05}); q0.push_back({1'b0, 8'h05});
        q0.push_back({1'b0, 8'h06}); q0.push_back({1'b0, 8'h06});
        ready_pct = 0;
        repeat (8) cycle();
        check("t6_pre_valid", m_valid, 1);
        check("t6_pre_data", m_data, 16'h0502);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_rst", {m_valid, m_src, m_last, m_data, s0_ready, s1_ready}, 0);
        ready_pct = 100;
        do_reset();
        pkt.push_back(8'h06); pkt.push_back(8'h06); pkt.push_back(8'h06);
        add_packet(0);
        run_drain(200);
        check("t6_count", out_log.size(), 1);
        check("t6_w0", log_at(0), {1'b0, 1'b1, 16'h0603});

        // Random traffic on both sources with random back-pressure.
        do_reset();
        valid_pct = 70;
        ready_pct = 60;
        for (int p = 0; p < 40; p++) begin
            s = int'($urandom_range(1));
            if ($urandom_range(7) == 0) begin
                len = int'($urandom_range(520, 250));
                b   = 8'($urandom);
                for (int k = 0; k < len; k++) pkt.push_back(b);
            end else begin
                len = int'($urandom_range(24, 1));
                for (int k = 0; k < len; k++) pkt.push_back(8'h30 + 8'($urandom_range(2)));
            end
            add_packet(s);
        end
        run_drain(40000);
        check("t7_no_open_pkt", in_pkt, 0);
`ifdef RLE_STATS_EN
        check("t7_stats", stat_words, words_seen);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
